port_rw_serializer_n: RTL and testbench
=======================================

// Module: port_rw_serializer_n
// PURPOSE
// - N-channel successor of the 3-entry port serializer: merges up to NPORTS same-cycle
//   read/write requests into one request per cycle toward the single-ported memory core.
// - Lowest-latency beat passes through combinationally; remaining valid entries are snapshotted
//   and drained in priority order, and invalid slots are skipped (no bubbles).
// - Adds sout_ready backpressure, a granted-port index and a pending count.
// - Sits between the port front-ends and the memory array.
// PARAMETERS
// - WIDTH   8  request payload width (addr+data+we packed by caller)
// - NPORTS  3  number of input channels, >=2
// - PW      (derived) max(1,$clog2(NPORTS)); CW = $clog2(NPORTS+1)
// PORTS
// - clk            in   1             clock, rising edge
// - reset_n        in   1             asynchronous, active-low reset
// - in_data        in   NPORTS*WIDTH  packed entries, port i at [i*WIDTH +: WIDTH]
// - in_valid       in   NPORTS        per-port valid
// - sout_ready     in   1             downstream accepts beat when sout_valid&sout_ready
// - sout_data      out  WIDTH         serialized payload
// - sout_valid     out  1             serialized valid
// - sout_port      out  PW            index of port currently presented
// - pending_cnt    out  CW            entries held in snapshot buffer
// - freeze_inputs  out  1             upstream must hold/stall; in_* must not depend on it combinationally
// BEHAVIOUR
// - Reset (async): state=IDLE, snapshot mask/data=0, pending_cnt=0, RR pointer=0;
//   while reset_n=0: sout_valid=0, sout_data=0, sout_port=0, freeze_inputs=0.
// - sout_data=0 and sout_port=0 whenever sout_valid=0.
// - FSM: IDLE, DRAIN.
// - IDLE: freeze_inputs=0; sout presents highest-priority valid port from in_* (0-cycle latency).
//   - no valid -> stay IDLE.
//   - ready=1 and exactly one valid -> beat consumed, stay IDLE.
//   - ready=1 and >1 valid -> snapshot = in_valid minus granted port; go DRAIN.
//   - ready=0 and >=1 valid -> snapshot all valid entries (none consumed); go DRAIN.
// - DRAIN: freeze_inputs=1; in_* ignored; sout presents highest-priority set bit of the snapshot.
//   - On handshake: clear that bit and decrement pending_cnt.
//   - When the last bit clears: go IDLE (freeze_inputs=0 the following cycle).
//   - ready=0: sout_data/sout_port/sout_valid held stable.
// - pending_cnt = popcount(snapshot mask); max NPORTS (ready=0 capture), else <=NPORTS-1.
// - Priority: lowest index first (fixed) unless SERIALIZER_RR_EN.
// - Reset mid-DRAIN: snapshot discarded, no further beats emitted.
// - Order within a burst is never changed by later in_* activity.
// CONFIGURATION
// - SERIALIZER_RR_EN defined: rotating priority. Pointer ptr (PW bits); search order
//   ptr, ptr+1, ... mod NPORTS. On every handshake ptr <= (granted+1) mod NPORTS
//   (wrap NPORTS-1 -> 0). Applies in IDLE and DRAIN.
// - Undefined: fixed lowest-index-first; no pointer register.
// TESTING (NPORTS=4, WIDTH=8)
// - IDLE, in_valid=0100, port2=0x5A, ready=1 -> same cycle sout_valid=1, data=0x5A, port=2,
//   freeze=0; next cycle IDLE.
// - in_valid=1111, data 0x10..0x13, ready=1 -> beats 0x10 (c0), 0x11, 0x12, 0x13 (c1-c3);
//   freeze=1 and pending_cnt=3,2,1 in c1-c3; freeze=0 in c4.
// - in_valid=1001, ready=1 -> 2 beats, ports 0 then 3, consecutive cycles, no bubble.
// - ready=0 with in_valid=0111 -> DRAIN, pending_cnt=3, sout port0 held stable;
//   ready=1 -> ports 0, 1, 2 over 3 cycles.
// - reset_n low during DRAIN with pending_cnt=2 -> sout_valid=0, freeze=0, pending_cnt=0
//   immediately; no beats after release.
// - RR_EN: burst in_valid=0110 drains ports 1, 2 (ptr->3); next burst 1111 drains 3, 0, 1, 2.
//   Without the macro the second burst drains 0, 1, 2, 3.

Source files
------------

// File: rtl/port_rw_serializer_n.sv
// ---------------------------------------------------------------------------
// port_rw_serializer_n
//   Merges up to NPORTS same-cycle read/write requests into one request per
//   cycle for a single-ported memory core. The highest-priority valid port
//   passes straight through combinationally. Any entries left over are
//   snapshotted and drained in priority order with no bubbles. While the
//   snapshot drains, upstream is frozen.
//
// Optional feature macro: SERIALIZER_RR_EN
//   Defined   : rotating priority. The search starts at ptr. On every
//               handshake ptr advances to (granted+1) mod NPORTS.
//   Undefined : fixed lowest-index-first priority with no pointer register.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   in_data        in   NPORTS*WIDTH packed entries, port i at [i*WIDTH +: WIDTH]
//   in_valid       in   per-port valid
//   sout_ready     in   downstream accepts a beat when sout_valid & sout_ready
//   sout_data      out  serialized payload (0 when sout_valid=0)
//   sout_valid     out  serialized valid
//   sout_port      out  index of the presented port (0 when sout_valid=0)
//   pending_cnt    out  number of entries held in the snapshot buffer
//   freeze_inputs  out  upstream must stall (registered, state-derived)
//
// States
//   IDLE  | passing in_* through; snapshot empty
//   DRAIN | emitting snapshot entries; in_* ignored, upstream frozen
// ---------------------------------------------------------------------------
module port_rw_serializer_n #(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 3,
    parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    parameter int CW     = $clog2(NPORTS + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS*WIDTH-1:0]  in_data,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic                     sout_ready,
    output logic [WIDTH-1:0]         sout_data,
    output logic                     sout_valid,
    output logic [PW-1:0]            sout_port,
    output logic [CW-1:0]            pending_cnt,
    output logic                     freeze_inputs
);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t                  state;
    logic [NPORTS-1:0]       snap_mask;
    logic [NPORTS*WIDTH-1:0] snap_data;

    logic [NPORTS-1:0]       src_mask;
    logic [NPORTS*WIDTH-1:0] src_data;
    logic [PW-1:0]           base;
    logic                    found;
    logic [PW-1:0]           grant;
    logic [NPORTS-1:0]       grant_oh;
    logic [WIDTH-1:0]        sel_data;
    logic                    hs;
    logic [NPORTS-1:0]       idle_rem;
    logic [NPORTS-1:0]       drain_rem;

    function automatic logic [CW-1:0] popcount(input logic [NPORTS-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NPORTS; i++) c = c + CW'(m[i]);
        return c;
    endfunction

    assign src_mask = (state == IDLE) ? in_valid : snap_mask;
    assign src_data = (state == IDLE) ? in_data  : snap_data;

    // Priority search starting at base and wrapping modulo NPORTS.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        grant_oh = '0;
        sel_data = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(base) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && src_mask[idx]) begin
                found         = 1'b1;
                grant         = PW'(idx);
                grant_oh[idx] = 1'b1;
                sel_data      = src_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Gating with reset_n keeps the outputs quiet while reset is held,
    // even if in_valid is already active.
    assign sout_valid    = found & reset_n;
    assign sout_data     = sout_valid ? sel_data : '0;
    assign sout_port     = sout_valid ? grant : '0;
    assign freeze_inputs = (state == DRAIN);
    assign hs            = sout_valid & sout_ready;

    // Leftovers: if ready=0 nothing was consumed, so everything is kept.
    assign idle_rem  = sout_ready ? (in_valid & ~grant_oh) : in_valid;
    assign drain_rem = snap_mask & ~grant_oh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            snap_mask   <= '0;
            snap_data   <= '0;
            pending_cnt <= '0;
        end else if (state == IDLE) begin
            if (idle_rem != '0) begin
                snap_mask   <= idle_rem;
                snap_data   <= in_data;
                pending_cnt <= popcount(idle_rem);
                state       <= DRAIN;
            end
        end else begin
            if (hs) begin
                snap_mask   <= drain_rem;
                pending_cnt <= pending_cnt - 1'b1;
                if (drain_rem == '0) state <= IDLE;
            end
        end
    end

`ifdef SERIALIZER_RR_EN
    logic [PW-1:0] ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (hs)
            ptr <= (grant == PW'(NPORTS - 1)) ? '0 : grant + 1'b1;
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

endmodule

// File: tb/tb_port_rw_serializer_n.sv
module tb_port_rw_serializer_n;

    localparam int WIDTH  = 8;
    localparam int NPORTS = 4;
    localparam int PW     = 2;
    localparam int CW     = 3;

    logic                     clk;
    logic                     reset_n;
    logic [NPORTS*WIDTH-1:0]  in_data;
    logic [NPORTS-1:0]        in_valid;
    logic                     sout_ready;
    logic [WIDTH-1:0]         sout_data;
    logic                     sout_valid;
    logic [PW-1:0]            sout_port;
    logic [CW-1:0]            pending_cnt;
    logic                     freeze_inputs;

    int checks = 0;
    int errors = 0;

    port_rw_serializer_n #(.WIDTH(WIDTH), .NPORTS(NPORTS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .sout_ready    (sout_ready),
        .sout_data     (sout_data),
        .sout_valid    (sout_valid),
        .sout_port     (sout_port),
        .pending_cnt   (pending_cnt),
        .freeze_inputs (freeze_inputs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ep;
        logic        ef;
        logic [2:0]  ec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rst, logic [3:0] v, logic [31:0] d, logic rdy,
                                logic ev, logic [7:0] ed, logic [1:0] ep,
                                logic ef, logic [2:0] ec);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
        t.ev = ev; t.ed = ed; t.ep = ep; t.ef = ef; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic [1:0] ep, input logic ef, input logic [2:0] ec);
        chk({tag, ".valid"},  32'(sout_valid),    32'(ev));
        chk({tag, ".data"},   32'(sout_data),     32'(ed));
        chk({tag, ".port"},   32'(sout_port),     32'(ep));
        chk({tag, ".freeze"}, 32'(freeze_inputs), 32'(ef));
        chk({tag, ".cnt"},    32'(pending_cnt),   32'(ec));
    endtask

    // Reset is held with requests present so the output gating is exercised.
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n    = 1'b0;
        in_valid   = 4'b1111;
        in_data    = 32'hA5A5A5A5;
        sout_ready = 1'b1;
        #2;
        chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0, 3'd0);
        @(negedge clk);
        in_valid = '0;
        reset_n  = 1'b1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic rdy);
        @(posedge clk); #1;
        in_valid   = v;
        in_data    = d;
        sout_ready = rdy;
        @(negedge clk);
    endtask

    int exp_order[4];

    initial begin
        reset_n    = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        sout_ready = 1'b0;

        // single valid, pass-through
        tv.push_back(mk(1, 4'b0100, 32'h005A0000, 1, 1, 8'h5A, 2, 0, 0));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 0, 0));
        // full burst; in_* garbage during DRAIN must be ignored
        tv.push_back(mk(1, 4'b1111, 32'h13121110, 1, 1, 8'h10, 0, 0, 0));
        tv.push_back(mk(0, 4'b0001, 32'hFFFFFFFF, 1, 1, 8'h11, 1, 1, 3));
        tv.push_back(mk(0, 4'b1000, 32'hEEEEEEEE, 1, 1, 8'h12, 2, 1, 2));
        tv.push_back(mk(0, 4'b1111, 32'hDDDDDDDD, 1, 1, 8'h13, 3, 1, 1));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 0, 0));
        // sparse: ports 0 and 3 back to back
        tv.push_back(mk(1, 4'b1001, 32'h43000040, 1, 1, 8'h40, 0, 0, 0));
        tv.push_back(mk(0, 4'b0110, 32'hAAAAAAAA, 1, 1, 8'h43, 3, 1, 1));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 0, 0));
        // backpressure: capture all three, hold, then drain
        tv.push_back(mk(1, 4'b0111, 32'h00222120, 0, 1, 8'h20, 0, 0, 0));
        tv.push_back(mk(0, 4'b1000, 32'h99999999, 0, 1, 8'h20, 0, 1, 3));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 0, 1, 8'h20, 0, 1, 3));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 1, 8'h20, 0, 1, 3));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 1, 8'h21, 1, 1, 2));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 1, 8'h22, 2, 1, 1));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 0, 0));
        // single valid with ready=0 still goes through DRAIN
        tv.push_back(mk(1, 4'b0100, 32'h00770000, 0, 1, 8'h77, 2, 0, 0));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 1, 8'h77, 2, 1, 1));
        tv.push_back(mk(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            drive(tv[i].v, tv[i].d, tv[i].rdy);
            chk_out($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].ep, tv[i].ef, tv[i].ec);
        end

        // reset in the middle of a drain
        do_reset();
        drive(4'b0111, 32'h00525150, 1);
        chk_out("mid.c0", 1, 8'h50, 0, 0, 0);
        drive(4'b0000, 32'h00000000, 1);
        chk_out("mid.c1", 1, 8'h51, 1, 1, 2);
        #1;
        reset_n  = 1'b0;
        in_valid = 4'b1111;
        #1;
        chk_out("mid.rst", 0, 8'h00, 0, 0, 0);
        @(posedge clk); #1;
        in_valid = '0;
        reset_n  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_out($sformatf("mid.after%0d", c), 0, 8'h00, 0, 0, 0);
            @(posedge clk); #1;
        end

        // priority order of a second burst after a 0110 burst
`ifdef SERIALIZER_RR_EN
        exp_order = '{3, 0, 1, 2};
`else
        exp_order = '{0, 1, 2, 3};
`endif
        do_reset();
        drive(4'b0110, 32'h33323130, 1);
        chk_out("rr.a0", 1, 8'h31, 1, 0, 0);
        drive(4'b0000, 32'h00000000, 1);
        chk_out("rr.a1", 1, 8'h32, 2, 1, 1);
        drive(4'b1111, 32'h43424140, 1);
        chk_out("rr.b0", 1, 8'(8'h40 + exp_order[0]), 2'(exp_order[0]), 0, 0);
        for (int k = 1; k < 4; k++) begin
            drive(4'b0000, 32'h00000000, 1);
            chk_out($sformatf("rr.b%0d", k), 1, 8'(8'h40 + exp_order[k]),
                    2'(exp_order[k]), 1, 3'(4 - k));
        end
        drive(4'b0000, 32'h00000000, 1);
        chk_out("rr.end", 0, 8'h00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
